// File: rtl/nn_pkg.sv
// Shared constants for the fully-connected stages: widths, layer codes,
// per-layer sizes and the dense sequencer state encoding.
package nn_pkg;

  localparam int DATSIZE = 22;
  localparam int PARSIZE = 16;
  localparam int FPSHIFT = 14;
  localparam int ACCW    = 48;

  localparam logic [3:0] ST_IDLE   = 4'b0000;
  localparam logic [3:0] ST_DENSE2 = 4'b1000;
  localparam logic [3:0] ST_DENSE1 = 4'b1001;

  localparam int DENSE2_N_IN = 256;
  localparam int DENSE1_N_IN = 96;
  localparam int N_OUT       = 96;

  localparam logic [6:0] LAST_OUT = 7'(N_OUT - 1);

  typedef logic [2:0] dense_fsm_t;

  localparam dense_fsm_t S_IDLE  = 3'd0;
  localparam dense_fsm_t S_ISSUE = 3'd1;
  localparam dense_fsm_t S_DRAIN = 3'd2;
  localparam dense_fsm_t S_WRITE = 3'd3;
  localparam dense_fsm_t S_FIN   = 3'd4;

  function automatic logic layer_ok(input logic [3:0] sel);
    return (sel == ST_DENSE2) || (sel == ST_DENSE1);
  endfunction

  function automatic logic [7:0] last_in(input logic [3:0] sel);
    return (sel == ST_DENSE2) ? 8'(DENSE2_N_IN - 1) : 8'(DENSE1_N_IN - 1);
  endfunction

endpackage

// File: rtl/dense_mac_acc.sv
// Accumulator for one output neuron plus the bias/rescale/narrow stage.
// Build option: DENSE_SAT_EN selects saturating narrowing instead of wrap.
module dense_mac_acc
  import nn_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      en,
  input  logic signed [PARSIZE-1:0] w_data,
  input  logic signed [DATSIZE-1:0] act_data,
  input  logic signed [PARSIZE-1:0] b_data,
  output logic signed [DATSIZE-1:0] res_out
);

  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] w_ext;
  logic signed [ACCW-1:0] a_ext;
  logic signed [ACCW-1:0] b_ext;
  logic signed [ACCW-1:0] prod;
  logic signed [ACCW-1:0] res;

  assign w_ext = ACCW'(w_data);
  assign a_ext = ACCW'(act_data);
  assign b_ext = ACCW'(b_data);
  assign prod  = w_ext * a_ext;

  // Clear wins so a new neuron never inherits the previous sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod;
    end
  end

  assign res = (acc >>> FPSHIFT) + b_ext;

`ifdef DENSE_SAT_EN
  localparam logic signed [DATSIZE-1:0] D_MAX = {1'b0, {(DATSIZE-1){1'b1}}};
  localparam logic signed [DATSIZE-1:0] D_MIN = {1'b1, {(DATSIZE-1){1'b0}}};

  always_comb begin
    res_out = res[DATSIZE-1:0];
    if (res > ACCW'(D_MAX)) begin
      res_out = D_MAX;
    end else if (res < ACCW'(D_MIN)) begin
      res_out = D_MIN;
    end
  end
`else
  assign res_out = DATSIZE'(res);
`endif

endmodule

// File: rtl/dense_layer_engine.sv
// Sequencer for the dense stages: walks neurons and inputs, drives the
// parameter stores and activation buffer, writes one result per neuron.
module dense_layer_engine
  import nn_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [3:0]                layer_sel,
  output logic [3:0]                state,
  output logic                      w_en,
  output logic [6:0]                read_o,
  output logic [7:0]                read_i,
  input  logic signed [PARSIZE-1:0] w_data,
  input  logic signed [PARSIZE-1:0] b_data,
  output logic [7:0]                act_addr,
  input  logic signed [DATSIZE-1:0] act_data,
  output logic                      out_we,
  output logic [6:0]                out_addr,
  output logic signed [DATSIZE-1:0] out_data,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                fsm_state
);

  dense_fsm_t fsm;
  logic [3:0] layer;
  logic       mac_en;
  logic       mac_clr;
  logic signed [DATSIZE-1:0] mac_res;

  // Store contract: w_data/act_data answer the address presented one cycle
  // earlier; b_data answers read_o combinationally, so read_o holds in WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm    <= S_IDLE;
      layer  <= ST_IDLE;
      read_i <= '0;
      read_o <= '0;
      mac_en <= 1'b0;
    end else begin
      mac_en <= (fsm == S_ISSUE);
      case (fsm)
        S_IDLE: begin
          if (start) begin
            if (layer_ok(layer_sel)) begin
              layer  <= layer_sel;
              read_i <= '0;
              read_o <= '0;
              fsm    <= S_ISSUE;
            end else begin
              fsm <= S_FIN;
            end
          end
        end
        S_ISSUE: begin
          if (read_i == last_in(layer)) begin
            read_i <= '0;
            fsm    <= S_DRAIN;
          end else begin
            read_i <= read_i + 8'd1;
          end
        end
        S_DRAIN: fsm <= S_WRITE;
        S_WRITE: begin
          if (read_o == LAST_OUT) begin
            fsm <= S_FIN;
          end else begin
            read_o <= read_o + 7'd1;
            fsm    <= S_ISSUE;
          end
        end
        S_FIN: begin
          read_o <= '0;
          layer  <= ST_IDLE;
          fsm    <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  assign w_en      = (fsm == S_ISSUE);
  assign mac_clr   = w_en && (read_i == 8'd0);
  assign busy      = (fsm == S_ISSUE) || (fsm == S_DRAIN) || (fsm == S_WRITE);
  assign done      = (fsm == S_FIN);
  assign state     = busy ? layer : ST_IDLE;
  assign act_addr  = read_i;
  assign out_we    = (fsm == S_WRITE);
  assign out_addr  = read_o;
  assign out_data  = out_we ? mac_res : '0;
  assign fsm_state = fsm;

  dense_mac_acc u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (mac_clr),
    .en       (mac_en),
    .w_data   (w_data),
    .act_data (act_data),
    .b_data   (b_data),
    .res_out  (mac_res)
  );

endmodule

// File: tb/tb_dense_layer_engine.sv
// Self-checking bench for dense_layer_engine: table of layer runs, random
// data against a sum-of-products reference, plus restart/abort sequences.
module tb_dense_layer_engine;

  localparam int K_ONES = 0;
  localparam int K_RAMP = 1;
  localparam int K_SAT  = 2;
  localparam int K_RAND = 3;

`ifdef DENSE_SAT_EN
  localparam bit SAT_BUILD = 1'b1;
`else
  localparam bit SAT_BUILD = 1'b0;
`endif

  typedef struct {
    logic [3:0]         sel;
    int                 kind;
    int                 exp_cycles;
    int                 exp_writes;
    int                 exp_wen;
    bit                 chk_const;
    logic signed [21:0] exp_val;
  } vec_t;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [3:0]         layer_sel;
  logic [3:0]         state;
  logic               w_en;
  logic [6:0]         read_o;
  logic [7:0]         read_i;
  logic signed [15:0] w_data;
  logic signed [15:0] b_data;
  logic [7:0]         act_addr;
  logic signed [21:0] act_data;
  logic               out_we;
  logic [6:0]         out_addr;
  logic signed [21:0] out_data;
  logic               busy;
  logic               done;
  logic [2:0]         fsm_state;

  logic signed [15:0] w_mem [0:95][0:255];
  logic signed [21:0] act_mem [0:255];
  logic signed [15:0] b_mem [0:95];

  logic [28:0] exp_q[$];
  int passed, total;
  int write_cnt, done_cnt, wen_cnt, busy_cnt;
  bit chk_const;
  logic signed [21:0] const_val;
  vec_t vecs[5];

  dense_layer_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .layer_sel (layer_sel),
    .state     (state),
    .w_en      (w_en),
    .read_o    (read_o),
    .read_i    (read_i),
    .w_data    (w_data),
    .b_data    (b_data),
    .act_addr  (act_addr),
    .act_data  (act_data),
    .out_we    (out_we),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // parameter store and activation buffer models
  always @(posedge clk) begin
    if (w_en) w_data <= w_mem[read_o][read_i];
    act_data <= act_mem[act_addr];
  end
  assign b_data = b_mem[read_o];

  task automatic chk(input string name, input longint actv, input longint expv);
    total++;
    if (actv == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, actv, expv);
  endtask

  // scoreboard and event monitors
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (w_en) wen_cnt++;
      if (busy) busy_cnt++;
      if (out_we) begin
        write_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL sb_extra_write: got addr %0d data %0d expected no write", out_addr, out_data);
        end else begin
          chk("sb_write_addr_data", longint'({out_addr, out_data}), longint'(exp_q.pop_front()));
        end
        if (chk_const) chk("const_out_data", longint'(out_data), longint'(const_val));
      end
    end
  end

  // reference model: plain sum of products per neuron
  function automatic logic signed [21:0] narrow(input longint v);
`ifdef DENSE_SAT_EN
    if (v > 64'sd2097151) return 22'sd2097151;
    if (v < -64'sd2097152) return -22'sd2097152;
`endif
    return v[21:0];
  endfunction

  task automatic model_push(input logic [3:0] sel);
    int n_in;
    longint sum;
    if (sel == 4'b1000) n_in = 256;
    else if (sel == 4'b1001) n_in = 96;
    else return;
    for (int o = 0; o < 96; o++) begin
      sum = 0;
      for (int i = 0; i < n_in; i++) sum += longint'(w_mem[o][i]) * longint'(act_mem[i]);
      exp_q.push_back({7'(o), narrow((sum >>> 14) + longint'(b_mem[o]))});
    end
  endtask

  task automatic load(input int kind, input logic [3:0] sel);
    for (int o = 0; o < 96; o++) begin
      for (int i = 0; i < 256; i++) begin
        case (kind)
          K_ONES:  w_mem[o][i] = 16'sd16384;
          K_RAMP:  w_mem[o][i] = 16'sd8192;
          K_SAT:   w_mem[o][i] = 16'sd32604;
          default: w_mem[o][i] = 16'($urandom);
        endcase
      end
      case (kind)
        K_RAMP:  b_mem[o] = -16'sd16384;
        K_RAND:  b_mem[o] = 16'($urandom);
        default: b_mem[o] = 16'sd0;
      endcase
    end
    for (int i = 0; i < 256; i++) begin
      case (kind)
        K_ONES:  act_mem[i] = 22'sd16384;
        K_RAMP:  act_mem[i] = 22'(i);
        K_SAT:   act_mem[i] = 22'sd2097151;
        default: act_mem[i] = 22'($urandom_range(0, 32'h3fffff));
      endcase
    end
    model_push(sel);
  endtask

  // driver: pulse start, count cycles until done, optionally re-pulse start
  task automatic run(input logic [3:0] sel, input int budget, input int repulse_at,
                     output int cycles);
    write_cnt = 0; done_cnt = 0; wen_cnt = 0; busy_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    layer_sel = sel;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    while (!done && cycles < budget) begin
      @(negedge clk);
      cycles++;
      start = (cycles == repulse_at);
      if (cycles == repulse_at) layer_sel = 4'b1000;
      if (cycles == 5 && (sel == 4'b1000 || sel == 4'b1001)) chk("state_mid_run", state, sel);
    end
    start = 1'b0;
    @(negedge clk);
    chk("done_is_pulse", done, 0);
  endtask

  task automatic run_vec(input vec_t v, input int repulse_at, input bit do_load);
    int cycles;
    if (do_load) load(v.kind, v.sel);
    chk_const = v.chk_const;
    const_val = v.exp_val;
    run(v.sel, v.exp_cycles + 100, repulse_at, cycles);
    chk_const = 1'b0;
    chk("cycles_to_done", cycles, v.exp_cycles);
    chk("done_pulses", done_cnt, 1);
    chk("write_count", write_cnt, v.exp_writes);
    chk("w_en_cycles", wen_cnt, v.exp_wen);
    chk("busy_cycles", busy_cnt, (v.exp_writes > 0) ? v.exp_cycles - 1 : 0);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("idle_after_done", {busy, state, w_en, out_we}, 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    vec_t fresh;
    passed = 0; total = 0;
    write_cnt = 0; done_cnt = 0; wen_cnt = 0; busy_cnt = 0;
    chk_const = 1'b0; const_val = '0;
    rst_n = 1'b0; start = 1'b0; layer_sel = 4'b0000;
    w_data = '0; act_data = '0;
    for (int o = 0; o < 96; o++) b_mem[o] = '0;
    for (int i = 0; i < 256; i++) act_mem[i] = '0;

    vecs[0] = '{4'b1001, K_ONES, 96*98+1,  96, 96*96,  1'b1, 22'sd1572864};
    vecs[1] = '{4'b1000, K_RAMP, 96*258+1, 96, 96*256, 1'b1, -22'sd64};
    vecs[2] = '{4'b1001, K_SAT,  96*98+1,  96, 96*96,  SAT_BUILD, 22'sd2097151};
    vecs[3] = '{4'b1001, K_RAND, 96*98+1,  96, 96*96,  1'b0, 22'sd0};
    vecs[4] = '{4'b0110, K_RAND, 1,        0,  0,      1'b0, 22'sd0};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {state, w_en, read_o, read_i, act_addr, out_we, out_addr,
                          out_data, busy, done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 5; k++) run_vec(vecs[k], 0, 1'b1);

    // start re-pulsed mid-layer (with a different layer code) is ignored
    run_vec(vecs[3], 50, 1'b1);

    // reset mid-layer at neuron 10, then a fresh run
    load(K_RAND, 4'b1001);
    write_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    layer_sel = 4'b1001;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (write_cnt < 10 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_neuron10", write_cnt, 10);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_outputs_quiet", {out_we, busy, state, w_en, done}, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("abort_no_more_writes", write_cnt, 10);
    rst_n = 1'b1;
    @(negedge clk);
    fresh = vecs[3];
    run_vec(fresh, 0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
